// File: rtl/uart_rx_sampler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_rx_sampler_if
// Brief    : RX line / oversample inputs and shift-register control outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface uart_rx_sampler_if;
   logic rx_in;
   logic os_tick;
   logic serial_out;
   logic baud_tick_rx;
   logic en;
   logic busy;
   logic frame_done;
   logic frame_err;

   modport master (
      input  rx_in,
      input  os_tick,
      output serial_out,
      output baud_tick_rx,
      output en,
      output busy,
      output frame_done,
      output frame_err
   );

   modport slave (
      output rx_in,
      output os_tick,
      input  serial_out,
      input  baud_tick_rx,
      input  en,
      input  busy,
      input  frame_done,
      input  frame_err
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_rx_sampler
// Brief    : RX synchroniser, start-bit validation and mid-bit sample tick gen.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_rx_sampler #(
   parameter int OVERSAMPLE  = 16,
   parameter int FRAME_BITS  = 9,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic          clk,
   input  wire logic          reset,
   uart_rx_sampler_if.master  bus
);

   localparam int c_OS_W  = $clog2(OVERSAMPLE);
   localparam int c_BIT_W = $clog2(FRAME_BITS + 1);
   localparam logic [c_OS_W-1:0]  c_OS_HALF  = c_OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [c_OS_W-1:0]  c_OS_FULL  = c_OS_W'(OVERSAMPLE - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state, w_state_nxt;
   logic [c_OS_W-1:0]      r_os_cnt, w_os_nxt;
   logic [c_BIT_W-1:0]     r_bit_cnt, w_bit_nxt;
   logic                   r_en, w_en_nxt;
   logic                   r_tick, w_tick_nxt;
   logic                   r_done, w_done_nxt;
   logic                   r_err, w_err_nxt;
   logic                   r_busy;
   logic                   w_rx;

   // Idle-high reset value keeps a reset release from looking like a start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '1;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx_in};
   end

   assign w_rx = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_os_cnt  <= '0;
         r_bit_cnt <= '0;
         r_en      <= 1'b0;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_os_cnt  <= w_os_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_en      <= w_en_nxt;
         r_tick    <= w_tick_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_os_nxt    = r_os_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_en_nxt    = r_en;
      w_tick_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_en_nxt = 1'b0;
            if (!w_rx) begin
               w_state_nxt = S_START;
               w_os_nxt    = '0;
            end
         end
         S_START: begin
            if (bus.os_tick) begin
               if (r_os_cnt == c_OS_HALF) begin
                  if (!w_rx) begin
                     w_state_nxt = S_DATA;
                     w_os_nxt    = '0;
                     w_bit_nxt   = '0;
                     w_en_nxt    = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_os_nxt = r_os_cnt + c_OS_W'(1);
               end
            end
         end
         S_DATA: begin
            if (bus.os_tick) begin
               if (r_os_cnt == c_OS_FULL) begin
                  w_tick_nxt = 1'b1;
                  w_os_nxt   = '0;
                  w_bit_nxt  = r_bit_cnt + c_BIT_W'(1);
                  if (r_bit_cnt == c_BIT_LAST) w_state_nxt = S_STOP;
               end else begin
                  w_os_nxt = r_os_cnt + c_OS_W'(1);
               end
            end
         end
         // serial_out here is the value the shift register captures with the final tick.
         S_STOP: begin
            w_done_nxt  = 1'b1;
            w_err_nxt   = ~w_rx;
            w_en_nxt    = 1'b0;
            w_state_nxt = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            w_en_nxt = 1'b0;
            if (w_rx) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_en_nxt    = 1'b0;
         end
      endcase
   end

   assign bus.serial_out   = w_rx;
   assign bus.baud_tick_rx = r_tick;
   assign bus.en           = r_en;
   assign bus.busy         = r_busy;
   assign bus.frame_done   = r_done;
   assign bus.frame_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_rx_sampler
// Brief    : Scoreboard bench driving bit-period frames against a frame-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_rx_sampler;

   localparam int OVERSAMPLE = 16;
   localparam int FRAME_BITS = 9;
   localparam int CLK_PER_OS = 4;

   typedef struct {
      logic        val;
      int unsigned idx;
   } tick_exp_t;

   typedef struct {
      logic [6:0] data;
      logic       err;
   } frame_exp_t;

   logic clk;
   logic reset;

   uart_rx_sampler_if bus_if ();

   uart_rx_sampler #(
      .OVERSAMPLE  (OVERSAMPLE),
      .FRAME_BITS  (FRAME_BITS),
      .SYNC_STAGES (2)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   tick_exp_t   tickq[$];
   frame_exp_t  frameq[$];
   int          tests;
   int          fails;
   int unsigned issued;
   int unsigned os_seen;
   int unsigned clk_cnt;
   int          tick_total;
   int          en_hi_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: os_tick is high on every CLK_PER_OS-th clock.
   task automatic step();
      @(negedge clk);
      #1;
      clk_cnt++;
      bus_if.os_tick = (clk_cnt % CLK_PER_OS == 0);
      if (bus_if.os_tick) issued++;
   endtask

   task automatic send_bit(input logic b, input int n_os);
      bus_if.rx_in = b;
      repeat (n_os * CLK_PER_OS) step();
   endtask

   // Line changes land right after an os_tick so the synchroniser settles before the next one.
   task automatic align();
      while (clk_cnt % CLK_PER_OS != 1) step();
   endtask

   task automatic send_frame(input logic [6:0] d, input logic p, input logic s, input int abort_after);
      logic [8:0]  bits;
      int unsigned n0;
      int          n_exp;
      bits  = {s, p, d};
      align();
      n0    = issued;
      n_exp = (abort_after > 0) ? abort_after : FRAME_BITS;
      for (int i = 0; i < n_exp; i++)
         tickq.push_back('{val: bits[i],
                           idx: n0 + OVERSAMPLE/2 + OVERSAMPLE + OVERSAMPLE*i});
      if (abort_after == 0) frameq.push_back('{data: d, err: ~s});
      send_bit(1'b0, OVERSAMPLE);
      if (abort_after > 0) begin
         for (int i = 0; i < abort_after; i++) send_bit(bits[i], OVERSAMPLE);
         reset = 1'b1;
         #1;
         check("abort_en",     bus_if.en,           0);
         check("abort_busy",   bus_if.busy,         0);
         check("abort_tick",   bus_if.baud_tick_rx, 0);
         check("abort_done",   bus_if.frame_done,   0);
         bus_if.rx_in = 1'b1;
         repeat (8) step();
         reset = 1'b0;
         repeat (8) step();
      end else begin
         for (int i = 0; i < FRAME_BITS; i++) send_bit(bits[i], OVERSAMPLE);
      end
   endtask

   initial begin
      os_seen = 0;
      forever begin
         @(posedge clk);
         if (bus_if.os_tick) os_seen++;
      end
   end

   // Monitor: plays the downstream shift register and pops the scoreboard.
   initial begin
      int         mbit;
      logic [6:0] asm_data;
      tick_exp_t  te;
      frame_exp_t fe;
      mbit       = 0;
      asm_data   = '0;
      tick_total = 0;
      en_hi_cnt  = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mbit     = 0;
            asm_data = '0;
         end else begin
            if (bus_if.en) en_hi_cnt++;
            if (bus_if.baud_tick_rx) begin
               tick_total++;
               check("tick_expected", tickq.size() > 0, 1);
               if (tickq.size() > 0) begin
                  te = tickq.pop_front();
                  check("tick_bit",  bus_if.serial_out, te.val);
                  check("tick_time", os_seen,           te.idx);
                  check("en_at_tick", bus_if.en,        1);
               end
               if (mbit < 7) asm_data[mbit] = bus_if.serial_out;
               mbit++;
            end
            if (bus_if.frame_done) begin
               check("done_expected", frameq.size() > 0, 1);
               if (frameq.size() > 0) begin
                  fe = frameq.pop_front();
                  check("frame_err",  bus_if.frame_err, fe.err);
                  check("frame_data", asm_data,         fe.data);
               end
               check("ticks_in_frame", mbit,        FRAME_BITS);
               check("en_drop",        bus_if.en,   0);
               check("busy_at_done",   bus_if.busy, 1);
               mbit = 0;
            end else begin
               check("err_needs_done", bus_if.frame_err, 0);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         en0, tk0;
      logic [6:0] d;
      tests        = 0;
      fails        = 0;
      issued       = 0;
      clk_cnt      = 0;
      reset        = 1'b1;
      bus_if.rx_in   = 1'b1;
      bus_if.os_tick = 1'b0;
      repeat (3) step();
      check("rst_serial_out", bus_if.serial_out,   1);
      check("rst_en",         bus_if.en,           0);
      check("rst_busy",       bus_if.busy,         0);
      check("rst_tick",       bus_if.baud_tick_rx, 0);
      check("rst_done",       bus_if.frame_done,   0);
      check("rst_err",        bus_if.frame_err,    0);
      reset = 1'b0;

      repeat (200) step();
      check("idle_en",    bus_if.en,         0);
      check("idle_busy",  bus_if.busy,       0);
      check("idle_line",  bus_if.serial_out, 1);
      check("idle_ticks", tick_total,        0);

      send_frame(7'h45, 1'b1, 1'b1, 0);
      send_bit(1'b1, 2);
      check("busy_after_frame", bus_if.busy, 0);

      // Start glitch shorter than half a bit.
      en0 = en_hi_cnt;
      tk0 = tick_total;
      align();
      send_bit(1'b0, 5);
      send_bit(1'b1, 4);
      check("glitch_en",    en_hi_cnt,   en0);
      check("glitch_ticks", tick_total,  tk0);
      check("glitch_busy",  bus_if.busy, 0);

      // Framing error followed by a break.
      d = 7'($urandom);
      send_frame(d, 1'($urandom), 1'b0, 0);
      tk0 = tick_total;
      send_bit(1'b0, 40);
      check("break_busy",  bus_if.busy, 1);
      check("break_en",    bus_if.en,   0);
      check("break_ticks", tick_total,  tk0);
      send_bit(1'b1, 2);
      check("break_release", bus_if.busy, 0);

      send_frame(7'($urandom), 1'($urandom), 1'b1, 4);
      send_frame(7'h2A, 1'b1, 1'b1, 0);
      send_bit(1'b1, 2);

      send_frame(7'($urandom), 1'($urandom), 1'b1, 0);
      send_frame(7'($urandom), 1'($urandom), 1'b1, 0);
      send_bit(1'b1, 2);
      check("b2b_busy", bus_if.busy, 0);

      repeat (8) begin
         send_frame(7'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 0);
         send_bit(1'b1, $urandom_range(1, 3));
      end

      repeat (20) step();
      check("tickq_drained",  tickq.size(),  0);
      check("frameq_drained", frameq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
